// File: rtl/instr_mem_loader_if.sv
// Byte-stream load request and instruction-memory write bus for instr_mem_loader.
// The master side issues start/len/abort and streams bytes; the slave side writes words.
interface instr_mem_loader_if #(
   parameter int AW = 32
);
   logic          start;
   logic [AW-1:0] len;
   logic          abort;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] Dir;
   logic [31:0]   Inst;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, len, abort, byte_in, byte_valid,
      input  byte_ready, mem_we, Dir, Inst, busy, done, err
   );

   modport slave (
      input  start, len, abort, byte_in, byte_valid,
      output byte_ready, mem_we, Dir, Inst, busy, done, err
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit instructions and writes
// them to consecutive word addresses 0..len-1 of an instruction memory.
module instr_mem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  logic                clk,
   input  logic                rst,
   instr_mem_loader_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] dir_q, dir_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [23:0]   part_q, part_d;
   logic [31:0]   inst_q, inst_d;
   logic          err_q, err_d;
   logic          hs, len_ok;

   assign hs     = bus.byte_valid && (state_q == RECV);
   assign len_ok = (bus.len != '0) && (bus.len <= DEPTH_W);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         addr_q  <= '0;
         dir_q   <= '0;
         bcnt_q  <= '0;
         part_q  <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         dir_q   <= dir_d;
         bcnt_q  <= bcnt_d;
         part_q  <= part_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      dir_d   = dir_q;
      bcnt_d  = bcnt_q;
      part_d  = part_q;
      inst_d  = inst_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  len_d   = bus.len;
                  addr_d  = '0;
                  bcnt_d  = '0;
                  part_d  = '0;
                  state_d = RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RECV: begin
            // abort outranks a coincident handshake: the byte is swallowed
            if (bus.abort) begin
               bcnt_d  = '0;
               part_d  = '0;
               state_d = IDLE;
            end else if (hs) begin
               bcnt_d = bcnt_q + 2'd1;
               case (bcnt_q)
                  2'd0: part_d[7:0]   = bus.byte_in;
                  2'd1: part_d[15:8]  = bus.byte_in;
                  2'd2: part_d[23:16] = bus.byte_in;
                  default: begin
                     inst_d  = {bus.byte_in, part_q};
                     dir_d   = addr_q;
                     state_d = WRITE;
                  end
               endcase
            end
         end
         WRITE: begin
            if (bus.abort) begin
               bcnt_d  = '0;
               part_d  = '0;
               state_d = IDLE;
            end else if (addr_q == len_q - AW'(1)) begin
               state_d = FIN;
            end else begin
               addr_d  = addr_q + AW'(1);
               bcnt_d  = '0;
               part_d  = '0;
               state_d = RECV;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.byte_ready = (state_q == RECV);
   assign bus.mem_we     = (state_q == WRITE) && !bus.abort;
   assign bus.done       = (state_q == FIN) && !bus.abort;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err        = err_q;
   assign bus.Dir        = dir_q;
   assign bus.Inst       = inst_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: each load pushes the words it should produce; a monitor
// pops and compares on every mem_we and counts done/err pulses.
module tb_instr_mem_loader;
   localparam int DEPTH = 64;
   localparam int AW    = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instr_mem_loader_if #(.AW(AW)) bus ();
   instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [AW-1:0] dir;
      logic [31:0]   inst;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           mon_e;
   int            errors = 0, checks = 0;
   int            done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
   logic          prev_we = 1'b0;
   logic [31:0]   wdata [DEPTH];
   logic [AW-1:0] last_dir = '0;
   logic [31:0]   last_inst = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.mem_we) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: Dir=%0h Inst=%0h with empty scoreboard", bus.Dir, bus.Inst);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("write_dir", 64'(bus.Dir), 64'(mon_e.dir));
                  check("write_inst", 64'(bus.Inst), 64'(mon_e.inst));
               end
            end
            if (bus.done) begin
               done_cnt++;
               check("done_after_write", 64'(prev_we), 64'(1));
            end
            if (bus.err) err_cnt++;
            prev_we = bus.mem_we;
         end else begin
            prev_we = 1'b0;
         end
      end
   end

   // one program load; abort_at = byte index at which abort is raised (-1: none)
   task automatic load(input int n, input int gap, input int abort_at, input bit poke_start);
      int total, idx, cyc, nw;
      bit hs;
      total = n * 4;
      idx   = 0;
      cyc   = 0;
      nw    = (abort_at < 0) ? n : abort_at / 4;
      for (int w = 0; w < nw; w++) exp_q.push_back(wr_t'{dir: AW'(w), inst: wdata[w]});
      if (nw > 0) begin
         last_dir  = AW'(nw - 1);
         last_inst = wdata[nw-1];
      end
      if (abort_at < 0) exp_done++;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = AW'(n);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", 64'(bus.busy), 64'(1));
      while (idx < total && cyc < 4000) begin
         bus.byte_in = wdata[idx/4][8*(idx%4) +: 8];
         case (gap)
            0:       bus.byte_valid = 1'b1;
            1:       bus.byte_valid = (cyc % 2 == 0);
            default: bus.byte_valid = 1'($urandom_range(0, 1));
         endcase
         if (abort_at == idx) begin
            bus.abort      = 1'b1;
            bus.byte_valid = 1'b1;
         end
         if (poke_start && idx == 2) begin
            bus.start = 1'b1;
            bus.len   = AW'(1);
         end
         hs = bus.byte_valid && bus.byte_ready;
         @(posedge clk);
         if (hs) idx++;
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.abort) begin
            bus.abort      = 1'b0;
            bus.byte_valid = 1'b0;
            break;
         end
         if (hs && idx % 4 == 0) check("write_latency", 64'(bus.mem_we), 64'(1));
         cyc++;
      end
      bus.byte_valid = 1'b0;
      check("load_in_budget", 64'(cyc < 4000), 64'(1));
      cyc = 0;
      while (bus.busy && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("idle_after_load", 64'(bus.busy), 64'(0));
      check("done_count", 64'(done_cnt), 64'(exp_done));
      check("dir_hold", 64'(bus.Dir), 64'(last_dir));
      check("inst_hold", 64'(bus.Inst), 64'(last_inst));
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic bad_len(input logic [AW-1:0] l);
      exp_err++;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = l;
      @(negedge clk);
      bus.start = 1'b0;
      check("bad_len_not_busy", 64'(bus.busy), 64'(0));
      repeat (3) @(negedge clk);
      check("bad_len_still_idle", 64'(bus.busy), 64'(0));
      check("err_count", 64'(err_cnt), 64'(exp_err));
   endtask

   task automatic rand_words(input int n);
      for (int i = 0; i < n; i++) wdata[i] = $urandom;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start      = 1'b0;
      bus.len        = '0;
      bus.abort      = 1'b0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) wdata[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_ready", 64'(bus.byte_ready), 64'(0));
      check("rst_we", 64'(bus.mem_we), 64'(0));
      check("rst_dir", 64'(bus.Dir), 64'(0));
      check("rst_inst", 64'(bus.Inst), 64'(0));
      check("rst_done_err", 64'({bus.done, bus.err}), 64'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      wdata[0] = 32'h00500513;
      load(1, 0, -1, 1'b0);

      wdata[0] = 32'h00500513;
      wdata[1] = 32'h00A00593;
      wdata[2] = 32'h00B50633;
      load(3, 0, -1, 1'b0);

      bad_len('0);
      bad_len(AW'(DEPTH + 1));

      rand_words(2);
      load(2, 1, -1, 1'b0);

      rand_words(4);
      load(4, 0, 6, 1'b0);
      rand_words(1);
      load(1, 0, -1, 1'b0);

      for (int k = 0; k < 6; k++) begin
         rand_words(8);
         load(int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), -1, k == 0);
      end

      rand_words(DEPTH);
      load(DEPTH, 0, -1, 1'b0);

      // asynchronous reset in the middle of RECV
      wdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = AW'(2);
      @(negedge clk);
      bus.start      = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hAA;
      @(posedge clk);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'(0));
      check("arst_ready", 64'(bus.byte_ready), 64'(0));
      check("arst_we_done_err", 64'({bus.mem_we, bus.done, bus.err}), 64'(0));
      check("arst_dir", 64'(bus.Dir), 64'(0));
      check("arst_inst", 64'(bus.Inst), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      last_dir  = '0;
      last_inst = '0;
      repeat (10) @(negedge clk);
      check("arst_needs_new_start", 64'(bus.busy), 64'(0));
      check("arst_no_done", 64'(done_cnt), 64'(exp_done));
      rand_words(1);
      load(1, 2, -1, 1'b0);

      check("err_total", 64'(err_cnt), 64'(exp_err));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning instruction memory size in 32-bit words.
REQ-002 The block SHALL have parameter AW, default 32, meaning width of the word address Dir.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  meaning a one-cycle request to begin a program load.
REQ-006 The block SHALL have port len  input  AW  meaning the number of words to load, sampled when start is accepted.
REQ-007 The block SHALL have port abort  input  1  meaning a synchronous cancel of the load in progress.
REQ-008 The block SHALL have port byte_in  input  8  meaning the incoming program byte.
REQ-009 The block SHALL have port byte_valid  input  1  meaning byte_in holds a valid byte.
REQ-010 The block SHALL have port byte_ready  output  1  meaning the loader accepts byte_in this cycle.
REQ-011 The block SHALL have port mem_we  output  1  meaning the instruction memory write strobe.
REQ-012 The block SHALL have port Dir  output  AW  meaning the word address of the write; word index, not byte address.
REQ-013 The block SHALL have port Inst  output  32  meaning the instruction word being written.
REQ-014 The block SHALL have port busy  output  1  meaning a load is in progress.
REQ-015 The block SHALL have port done  output  1  meaning a one-cycle pulse when the last word has been written.
REQ-016 The block SHALL have port err  output  1  meaning a one-cycle pulse when start is rejected.

Function
REQ-017 The block SHALL implement the FSM states IDLE, RECV, WRITE and FIN.
REQ-018 In IDLE, start=1 with 1<=len<=DEPTH SHALL latch len, clear the word address and the byte counter, and go to RECV on the next edge.
REQ-019 In IDLE, start=1 with len=0 or len>DEPTH SHALL pulse err for exactly one cycle, stay in IDLE, and produce no write.
REQ-020 When busy=1, start SHALL be ignored.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted on an edge where byte_valid=1 and byte_ready=1.
REQ-022 Bytes SHALL be assembled little-endian: the 1st accepted byte goes to Inst[7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-023 Acceptance of the 4th byte SHALL move the FSM to WRITE; gaps in byte_valid SHALL stall RECV with no timeout.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle, with Dir equal to the current word address and Inst equal to the assembled word.
REQ-025 Latency from 4th-byte acceptance to mem_we=1 SHALL be 1 cycle; the minimum word period SHALL be 5 cycles.
REQ-026 After WRITE, if the word address equals len-1 the FSM SHALL go to FIN; otherwise the word address SHALL increment by 1, the byte counter SHALL clear, and the FSM SHALL return to RECV.
REQ-027 In FIN, done SHALL be 1 for exactly one cycle, after which the FSM SHALL go to IDLE.
REQ-028 busy SHALL be 1 in RECV, WRITE and FIN, and 0 in IDLE.
REQ-029 The word address SHALL never exceed DEPTH-1 and SHALL never wrap.
REQ-030 abort=1 in RECV, WRITE or FIN SHALL send the FSM to IDLE on the next edge, discard any partial word, and force mem_we=0 and done=0 in that cycle.
REQ-031 If abort and a byte handshake occur on the same edge, abort SHALL win and the byte SHALL be counted as consumed but discarded.
REQ-032 Dir and Inst SHALL hold their last values outside WRITE, and memory SHALL only be qualified by mem_we.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE and mem_we, Dir, Inst, byte_ready, busy, done, err and all counters to 0, regardless of clk.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further write, and the next load after rst=1 SHALL require a new start.

Verification
REQ-035 Scenario: len=1, bytes 0x13,0x05,0x50,0x00 back-to-back -> one mem_we at Dir=0 with Inst=0x00500513, done 1 cycle later, busy=0 afterwards.
REQ-036 Scenario: len=3, twelve bytes encoding 0x00500513, 0x00A00593, 0x00B50633 -> writes at Dir 0, 1, 2 in order, and exactly 3 mem_we pulses.
REQ-037 Scenario: len=0, then len=DEPTH+1 -> err pulses once each, with no mem_we and busy staying 0.
REQ-038 Scenario: byte_valid toggled 1/0 every cycle during a len=2 load -> the same data as back-to-back, and no byte accepted while byte_ready=0.
REQ-039 Scenario: abort after the 2nd byte of word 1 (len=4) -> only Dir=0 written, FSM in IDLE, and a following len=1 load writes at Dir=0.
REQ-040 Scenario: rst=0 pulsed between clock edges during RECV -> outputs go to 0 asynchronously, with no write and no done.
